lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store controller between the single-cycle CPU datapath and the word-addressed data RAM (256 x 32, combinational read, level-sensitive write). Translates byte-addressed CPU requests of byte, halfword or word size into RAM strobes. Sub-word stores use read-modify-write; loads are lane-extracted with sign or zero extension. Drives the RAM's write, load, address and write-data inputs and consumes its read data.

Parameters:
ADDR_WORDS, 256, RAM depth in 32-bit words; must be a power of 2. IDX_W = log2(ADDR_WORDS).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
mem_req  in  1  CPU request; sampled only in IDLE
mem_we  in  1  1 = store, 0 = load
mem_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal
mem_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
mem_addr  in  32  byte address
mem_wdata  in  32  store data, right-aligned
mem_rdata  out  32  load result, valid while mem_ready=1
mem_ready  out  1  one-cycle completion pulse
mem_err  out  1  qualifies mem_ready: request rejected
busy  out  1  high in every state except IDLE
ram_write  out  1  RAM write strobe
ram_load  out  1  RAM read enable
ram_addr  out  32  RAM word index, zero-extended
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data; high-Z unless ram_load=1

Behaviour:
- Reset (async, immediate): state=IDLE. mem_rdata, mem_ready, mem_err, busy, ram_write, ram_load, ram_addr and ram_wdata all 0. Reset mid-operation drops RAM strobes at once. No partial write is retried.
- All outputs are registered and Moore-decoded from state. No combinational path from CPU inputs to RAM outputs.
- Accept: in IDLE with mem_req=1, latch addr, wdata, size, we and unsigned at the edge. The CPU may change its inputs after accept.
- Word index = addr[IDX_W+1:2]. Byte offset off = addr[1:0].
- Error, checked at accept: size=11; halfword with off[0]=1; word with off!=0; or addr[31:IDX_W+2] != 0. On error go IDLE -> DONE with mem_err=1 and mem_rdata=0. No RAM strobes are issued.
- States: IDLE, RD, RMW_RD, WR, DONE.
  - Load: IDLE -> RD -> DONE.
    - RD: ram_load=1, ram_addr=index; the word is captured at the end of RD.
    - DONE: mem_ready=1 and mem_rdata = extracted lane.
    - mem_ready rises 2 cycles after the accept edge.
  - Word store: IDLE -> WR -> DONE.
    - WR: ram_write=1 for exactly one cycle, ram_wdata=latched wdata, ram_load=0.
  - Sub-word store: IDLE -> RMW_RD -> WR -> DONE.
    - RMW_RD: ram_load=1; capture the old word.
    - WR: ram_wdata = old word with the target lane replaced, little-endian. Byte lane = bits [8*off+7 : 8*off] gets wdata[7:0]. Halfword lane = bits [8*off+15 : 8*off] gets wdata[15:0].
    - mem_ready rises 3 cycles after accept.
- ram_addr holds its value through DONE and returns to 0 in IDLE. ram_wdata returns to 0 in IDLE.
- ram_write and ram_load are never high together.
- Load extension: byte gives lane[7:0] extended to 32; halfword gives lane[15:0] extended; word is passed through.
- DONE always lasts one cycle, then IDLE. mem_req during DONE is ignored; a held mem_req is re-accepted in the following IDLE cycle. The CPU must drop mem_req in DONE to avoid a repeat access.
- mem_err is 0 on every successful completion. Store completions drive mem_rdata=0.

Test Plan:
1. Word store then load: store 0xDEADBEEF at addr 0x10 -> WR cycle shows ram_addr=4 and ram_wdata=0xDEADBEEF. Then load word at 0x10 -> mem_rdata=0xDEADBEEF, mem_ready 2 cycles after accept.
2. Byte RMW: RAM[4]=0x11223344; store byte 0xAA at 0x12 -> exactly one RMW_RD and one WR cycle, ram_wdata=0x11AA3344, mem_ready 3 cycles after accept.
3. Extension: RAM[4]=0x80FF7F01. Load byte at 0x12, signed -> 0xFFFFFFFF. Unsigned -> 0x000000FF. Load halfword at 0x12, signed -> 0xFFFF80FF.
4. Errors: word load at 0x11, halfword store at 0x13, size=11, and addr 0x400 -> each gives mem_ready=1 with mem_err=1 one cycle after accept. ram_write and ram_load stay 0, and RAM contents are unchanged.
5. Reset mid-operation: assert rst_n=0 during the RMW_RD of a byte store -> all outputs go to 0 immediately. RAM word is unchanged. After release, busy=0 and a new request is accepted.
6. Held request: keep mem_req=1 across a word load -> second accept occurs in the IDLE cycle after DONE. Two mem_ready pulses 3 cycles apart, and ram_load and ram_write are never high together.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the CPU datapath and a word-addressed data RAM.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy,
  output logic        ram_write,
  output logic        ram_load,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned IDX_W = $clog2(ADDR_WORDS);

  typedef enum logic [2:0] {StIdle, StRd, StRmwRd, StWr, StDone} state_e;

  state_e      state_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [15:0] wdata_q;

  logic        req_err;
  logic [4:0]  shamt;
  logic [15:0] lane;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    req_err = (mem_addr[31:IDX_W+2] != '0) ||
              (mem_size == 2'b11) ||
              (mem_size == 2'b01 && mem_addr[0]) ||
              (mem_size == 2'b10 && mem_addr[1:0] != 2'b00);

    shamt = {off_q, 3'b000};
    lane  = 16'(ram_rdata >> shamt);

    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_val = uns_q ? {16'h0, lane} : {{16{lane[15]}}, lane};
      default: load_val = ram_rdata;
    endcase

    // Little-endian lane replacement on the word fetched in StRmwRd
    case (size_q)
      2'b00:   merged = (ram_rdata & ~(32'h0000_00ff << shamt)) |
                        ({24'h0, wdata_q[7:0]} << shamt);
      2'b01:   merged = (ram_rdata & ~(32'h0000_ffff << shamt)) |
                        ({16'h0, wdata_q} << shamt);
      default: merged = ram_rdata;
    endcase
  end

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      wdata_q   <= 16'h0;
      mem_rdata <= 32'h0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      busy      <= 1'b0;
      ram_write <= 1'b0;
      ram_load  <= 1'b0;
      ram_addr  <= 32'h0;
      ram_wdata <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (mem_req) begin
            off_q   <= mem_addr[1:0];
            size_q  <= mem_size;
            uns_q   <= mem_unsigned;
            wdata_q <= mem_wdata[15:0];
            busy    <= 1'b1;
            if (req_err) begin
              state_q   <= StDone;
              mem_ready <= 1'b1;
              mem_err   <= 1'b1;
            end else if (mem_we && mem_size == 2'b10) begin
              state_q   <= StWr;
              ram_write <= 1'b1;
              ram_addr  <= 32'(mem_addr[IDX_W+1:2]);
              ram_wdata <= mem_wdata;
            end else begin
              state_q  <= mem_we ? StRmwRd : StRd;
              ram_load <= 1'b1;
              ram_addr <= 32'(mem_addr[IDX_W+1:2]);
            end
          end
        end
        StRd: begin
          state_q   <= StDone;
          ram_load  <= 1'b0;
          mem_ready <= 1'b1;
          mem_rdata <= load_val;
        end
        StRmwRd: begin
          state_q   <= StWr;
          ram_load  <= 1'b0;
          ram_write <= 1'b1;
          ram_wdata <= merged;
        end
        StWr: begin
          state_q   <= StDone;
          ram_write <= 1'b0;
          mem_ready <= 1'b1;
          mem_rdata <= 32'h0;
        end
        StDone: begin
          state_q   <= StIdle;
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          mem_rdata <= 32'h0;
          busy      <= 1'b0;
          ram_addr  <= 32'h0;
          ram_wdata <= 32'h0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural 256 x 32 RAM.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;
  logic        busy;
  logic        ram_write;
  logic        ram_load;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  wire  [31:0] ram_rdata;

  logic [31:0] ram [256];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  int n_total;
  int n_bad;
  int both_cnt;
  int bad_addr_cnt;

  // Results of the last run_req
  int          r_lat;
  int          r_nwr;
  int          r_nld;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_busy;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;

  lsu_mem_ctrl #(.ADDR_WORDS(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .mem_err      (mem_err),
    .busy         (busy),
    .ram_write    (ram_write),
    .ram_load     (ram_load),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = ram_load ? ram[ram_addr[7:0]] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_val;
    else if (ram_write) ram[ram_addr[7:0]] <= ram_wdata;
  end

  always @(negedge clk) begin
    if (ram_write && ram_load) both_cnt++;
    if ((ram_write || ram_load) && ram_addr[31:8] != 24'h0) bad_addr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    mem_we       = we;
    mem_size     = size;
    mem_unsigned = uns;
    mem_addr     = addr;
    mem_wdata    = wdata;
    mem_req      = 1'b1;
  endtask

  // One request; latency counts negedges after the accept edge up to mem_ready.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    drive(we, size, uns, addr, wdata);
    @(posedge clk);
    #1;
    mem_req   = 1'b0;
    mem_wdata = 32'h0;
    mem_addr  = 32'h0;
    r_lat = 0; r_nwr = 0; r_nld = 0;
    r_rdata = 32'hx; r_err = 1'bx; r_busy = 1'b0;
    r_waddr = 32'hx; r_wdata = 32'hx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) r_busy = busy;
      if (ram_write) begin
        r_nwr++;
        r_waddr = ram_addr;
        r_wdata = ram_wdata;
      end
      if (ram_load) r_nld++;
      if (mem_ready) begin
        r_lat   = i;
        r_rdata = mem_rdata;
        r_err   = mem_err;
        break;
      end
    end
  endtask

  task automatic check_load(input string tag, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] exp);
    run_req(1'b0, size, uns, addr, 32'h0);
    check({tag, "_lat"}, r_lat, 2);
    check({tag, "_data"}, r_rdata, exp);
    check({tag, "_err"}, {31'h0, r_err}, 0);
  endtask

  task automatic check_error(input string tag, input logic we, input logic [1:0] size,
                             input logic [31:0] addr);
    run_req(we, size, 1'b0, addr, 32'h1234_5678);
    check({tag, "_lat"}, r_lat, 1);
    check({tag, "_err"}, {31'h0, r_err}, 1);
    check({tag, "_data"}, r_rdata, 0);
    check({tag, "_strobes"}, r_nwr + r_nld, 0);
  endtask

  int ready_cnt;
  int first_at;
  int second_at;
  logic [31:0] second_data;

  initial begin
    n_total = 0; n_bad = 0; both_cnt = 0; bad_addr_cnt = 0;
    pl_en = 1'b0; pl_idx = 8'h0; pl_val = 32'h0;
    rst_n = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, mem_ready}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_strobes", {30'h0, ram_write, ram_load}, 0);
    check("rst_addr", ram_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'h0, busy}, 0);

    // Word store then word load
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hdead_beef);
    check("wst_lat", r_lat, 2);
    check("wst_busy", {31'h0, r_busy}, 1);
    check("wst_nwr", r_nwr, 1);
    check("wst_nld", r_nld, 0);
    check("wst_addr", r_waddr, 32'h4);
    check("wst_wdata", r_wdata, 32'hdead_beef);
    check("wst_rdata", r_rdata, 0);
    check("wst_ram", ram[4], 32'hdead_beef);
    check_load("wld", 2'b10, 1'b0, 32'h10, 32'hdead_beef);
    @(negedge clk);
    check("idle_addr", ram_addr, 0);
    check("idle_wdata", ram_wdata, 0);

    // Byte and halfword read-modify-write
    preload(8'd4, 32'h1122_3344);
    run_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00aa);
    check("bst_lat", r_lat, 3);
    check("bst_nld", r_nld, 1);
    check("bst_nwr", r_nwr, 1);
    check("bst_wdata", r_wdata, 32'h11aa_3344);
    check("bst_err", {31'h0, r_err}, 0);
    check("bst_ram", ram[4], 32'h11aa_3344);
    preload(8'd5, 32'h0102_0304);
    run_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_cafe);
    check("hst_lat", r_lat, 3);
    check("hst_addr", r_waddr, 32'h5);
    check("hst_wdata", r_wdata, 32'hcafe_0304);
    preload(8'd5, 32'h0102_0304);
    run_req(1'b1, 2'b00, 1'b0, 32'h14, 32'hffff_ff5a);
    check("bst0_wdata", r_wdata, 32'h0102_035a);

    // Load extension
    preload(8'd4, 32'h80ff_7f01);
    check_load("lbs", 2'b00, 1'b0, 32'h12, 32'hffff_ffff);
    check_load("lbu", 2'b00, 1'b1, 32'h12, 32'h0000_00ff);
    check_load("lhs", 2'b01, 1'b0, 32'h12, 32'hffff_80ff);
    check_load("lb1", 2'b00, 1'b0, 32'h11, 32'h0000_007f);
    check_load("lb3", 2'b00, 1'b0, 32'h13, 32'hffff_ff80);
    check_load("lhu0", 2'b01, 1'b1, 32'h10, 32'h0000_7f01);
    check_load("lhs0", 2'b01, 1'b0, 32'h10, 32'h0000_7f01);

    // Rejected requests
    check_error("e_wmis", 1'b0, 2'b10, 32'h11);
    check_error("e_hmis", 1'b1, 2'b01, 32'h13);
    check_error("e_size", 1'b0, 2'b11, 32'h10);
    check_error("e_range", 1'b0, 2'b10, 32'h400);
    check("e_ram", ram[4], 32'h80ff_7f01);

    // Reset during the RMW read of a byte store
    preload(8'd6, 32'h5566_7788);
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b0, 32'h18, 32'h99);
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    @(negedge clk);
    check("mid_load", {31'h0, ram_load}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_load", {31'h0, ram_load}, 0);
    check("mid_rst_busy", {31'h0, busy}, 0);
    check("mid_rst_addr", ram_addr, 0);
    check("mid_rst_misc", {28'h0, ram_write, mem_ready, mem_err, |{ram_wdata, mem_rdata}}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_ram", ram[6], 32'h5566_7788);
    check("mid_busy", {31'h0, busy}, 0);
    check_load("mid_new", 2'b10, 1'b0, 32'h18, 32'h5566_7788);

    // Held request: re-accepted in the IDLE cycle after DONE
    ready_cnt = 0; first_at = 0; second_at = 0; second_data = 32'h0;
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        ready_cnt++;
        if (ready_cnt == 1) first_at = i;
        if (ready_cnt == 2) begin
          second_at   = i;
          second_data = mem_rdata;
          mem_req     = 1'b0;
        end
      end
    end
    mem_req = 1'b0;
    check("held_first", first_at, 2);
    check("held_gap", second_at - first_at, 3);
    check("held_count", ready_cnt, 2);
    check("held_data", second_data, 32'h80ff_7f01);

    check("never_both", both_cnt, 0);
    check("strobe_range", bad_addr_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
